// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch definitions: FSM states, halt sentinel,
// and the IF/ID bundle also consumed by the decode stage.
package fetch_sequencer_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/fetch_sequencer_ifid_reg.sv
// IF/ID pipeline register: load a fetched word,
// hold it, or turn it into a bubble.
module ifid_reg
  import fetch_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  output if_id_t             q
);

  // load wins; bubble only drops valid; otherwise hold
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q.instr <= instr_in;
      q.pc    <= pc_in;
      q.valid <= 1'b1;
    end else if (bubble) begin
      q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch FSM and PC; IF/ID held in ifid_reg.
// FETCH_SEQ_PERF_EN adds perf_fetched/perf_bubbles.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned         MEM_DEPTH = 32,
  parameter logic [PC_W-1:0]     RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]  HALT_WORD =
    fetch_sequencer_pkg::HALT_WORD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [PC_W-1:0]    imem_addr,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  output logic               halted,
`ifdef FETCH_SEQ_PERF_EN
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles,
`endif
  output logic               fault
);

  localparam logic [PC_W-1:0] DEPTH = PC_W'(MEM_DEPTH);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic            load, bubble;
  if_id_t          ifid;

  logic [PC_W-1:0] seq_pc;
  logic            seq_ok, redir_ok;
  logic            do_redir, do_stall;
  logic            do_halt, do_fetch;

  assign seq_pc   = pc_q + 1'b1;
  assign seq_ok   = seq_pc < DEPTH;
  assign redir_ok = redirect_pc < DEPTH;

  assign do_redir = redirect;
  assign do_stall = !redirect && stall;
  assign do_halt  = !redirect && !stall &&
                    (imem_data == HALT_WORD);
  assign do_fetch = !redirect && !stall &&
                    (imem_data != HALT_WORD);

  // state, PC and sticky fault registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  // next state, next PC and IF/ID controls
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    load    = 1'b0;
    bubble  = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
        end
      end
      S_RUN: begin
        unique case (1'b1)
          do_redir: begin
            bubble = 1'b1;
            if (redir_ok) begin
              pc_d = redirect_pc;
            end else begin
              fault_d = 1'b1;
              state_d = S_HALTED;
            end
          end
          do_stall: ;
          do_halt: begin
            bubble  = 1'b1;
            state_d = S_HALTED;
          end
          do_fetch: begin
            if (seq_ok) begin
              load = 1'b1;
              pc_d = seq_pc;
            end else begin
              bubble  = 1'b1;
              fault_d = 1'b1;
              state_d = S_HALTED;
            end
          end
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  ifid_reg u_ifid (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .bubble   (bubble),
    .instr_in (imem_data),
    .pc_in    (pc_q),
    .q        (ifid)
  );

  assign imem_addr   = pc_q;
  assign instr       = ifid.instr;
  assign instr_pc    = ifid.pc;
  assign instr_valid = ifid.valid;
  assign halted      = (state_q == S_HALTED);
  assign fault       = fault_q;

`ifdef FETCH_SEQ_PERF_EN
  logic run, clr, fetch_ev, bub_ev;
  assign run      = (state_q == S_RUN);
  assign clr      = start && !run;
  assign fetch_ev = run && load;
  assign bub_ev   = run && !load;

  // saturating fetch / bubble counters
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (fetch_ev && perf_fetched != '1)
        perf_fetched <= perf_fetched + 1'b1;
      if (bub_ev && perf_bubbles != '1)
        perf_bubbles <= perf_bubbles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table
// plus hand sequences for reset and perf counters.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, stall, redirect;
  logic [31:0] redirect_pc, imem_data, imem_addr;
  logic [31:0] instr, instr_pc;
  logic        instr_valid, halted, fault;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] mem [32];

  typedef struct {
    logic        st, sl, rd;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic [31:0] ipc;
    logic        v, h, f;
  } vec_t;

  vec_t tv [25];

  always #5 clk = ~clk;

  assign imem_data = (imem_addr < 32'd32) ?
                     mem[imem_addr[4:0]] : 32'h0;

  fetch_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_data   (imem_data),
    .imem_addr   (imem_addr),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .halted      (halted),
`ifdef FETCH_SEQ_PERF_EN
    .perf_fetched(perf_fetched),
    .perf_bubbles(perf_bubbles),
`endif
    .fault       (fault)
  );

  function automatic logic [31:0] word(input logic [31:0] i);
    word = 32'h0022_0021 | (i << 11);
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic st, input logic sl,
                      input logic rd, input logic [31:0] rpc);
    start       = st;
    stall       = sl;
    redirect    = rd;
    redirect_pc = rpc;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = word(i);
    mem[4] = 32'hFFFF_FFFF;

    //        st sl rd rpc  addr ipc v  h  f
    tv[0]  = '{1, 0, 0, 0,  0,   0,  0, 0, 0};
    tv[1]  = '{0, 0, 0, 0,  1,   0,  1, 0, 0};
    tv[2]  = '{0, 0, 0, 0,  2,   1,  1, 0, 0};
    tv[3]  = '{0, 0, 0, 0,  3,   2,  1, 0, 0};
    tv[4]  = '{0, 0, 0, 0,  4,   3,  1, 0, 0};
    tv[5]  = '{0, 0, 0, 0,  4,   0,  0, 1, 0};
    tv[6]  = '{0, 1, 1, 7,  4,   0,  0, 1, 0};
    tv[7]  = '{1, 0, 0, 0,  0,   0,  0, 0, 0};
    tv[8]  = '{0, 0, 0, 0,  1,   0,  1, 0, 0};
    tv[9]  = '{0, 0, 0, 0,  2,   1,  1, 0, 0};
    tv[10] = '{0, 1, 0, 0,  2,   1,  1, 0, 0};
    tv[11] = '{0, 1, 0, 0,  2,   1,  1, 0, 0};
    tv[12] = '{0, 1, 0, 0,  2,   1,  1, 0, 0};
    tv[13] = '{0, 0, 0, 0,  3,   2,  1, 0, 0};
    tv[14] = '{0, 0, 1, 10, 10,  0,  0, 0, 0};
    tv[15] = '{0, 0, 0, 0,  11,  10, 1, 0, 0};
    tv[16] = '{0, 1, 1, 20, 20,  0,  0, 0, 0};
    tv[17] = '{1, 0, 0, 0,  21,  20, 1, 0, 0};
    tv[18] = '{0, 0, 1, 40, 21,  0,  0, 1, 1};
    tv[19] = '{1, 0, 0, 0,  0,   0,  0, 0, 1};
    tv[20] = '{0, 0, 0, 0,  1,   0,  1, 0, 1};
    tv[21] = '{0, 0, 1, 31, 31,  0,  0, 0, 1};
    tv[22] = '{0, 0, 0, 0,  31,  0,  0, 1, 1};
    tv[23] = '{1, 0, 0, 0,  0,   0,  0, 0, 1};
    tv[24] = '{0, 0, 1, 32, 0,   0,  0, 1, 1};

    reset = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst addr",  imem_addr, 32'd0);
    chk("rst instr", instr, 32'd0);
    chk("rst ipc",   instr_pc, 32'd0);
    chk("rst valid", {31'd0, instr_valid}, 32'd0);
    chk("rst halted", {31'd0, halted}, 32'd0);
    chk("rst fault", {31'd0, fault}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      step(tv[i].st, tv[i].sl, tv[i].rd, tv[i].rpc);
      chk($sformatf("row%0d addr", i), imem_addr, tv[i].addr);
      chk($sformatf("row%0d valid", i),
          {31'd0, instr_valid}, {31'd0, tv[i].v});
      chk($sformatf("row%0d halted", i),
          {31'd0, halted}, {31'd0, tv[i].h});
      chk($sformatf("row%0d fault", i),
          {31'd0, fault}, {31'd0, tv[i].f});
      if (tv[i].v) begin
        chk($sformatf("row%0d ipc", i), instr_pc, tv[i].ipc);
        chk($sformatf("row%0d instr", i), instr,
            word(tv[i].ipc));
      end
    end

    // reset in the middle of RUN at PC 5
    step(1, 0, 0, 0);
    step(0, 0, 1, 5);
    chk("mid addr5", imem_addr, 32'd5);
    reset = 1'b1;
    step(0, 0, 0, 0);
    chk("mid rst addr", imem_addr, 32'd0);
    chk("mid rst valid", {31'd0, instr_valid}, 32'd0);
    chk("mid rst halted", {31'd0, halted}, 32'd0);
    chk("mid rst fault", {31'd0, fault}, 32'd0);
`ifdef FETCH_SEQ_PERF_EN
    chk("mid rst pf", perf_fetched, 32'd0);
    chk("mid rst pb", perf_bubbles, 32'd0);
`endif
    reset = 1'b0;
    step(0, 0, 0, 0);
    chk("idle addr", imem_addr, 32'd0);
    chk("idle valid", {31'd0, instr_valid}, 32'd0);

    // two fetches then one stall from a fresh start
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("seq addr", imem_addr, 32'd2);
    chk("seq ipc", instr_pc, 32'd1);
    chk("seq valid", {31'd0, instr_valid}, 32'd1);
`ifdef FETCH_SEQ_PERF_EN
    chk("perf fetched", perf_fetched, 32'd2);
    chk("perf bubbles", perf_bubbles, 32'd1);
    step(1, 0, 0, 0);
    chk("perf start run", perf_fetched, 32'd3);
`endif
    step(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
